sd_spi_master: RTL
==================

Name: sd_spi_master

Overview:
- Parametrised SPI-mode SD card master; successor of the single-card controller.
- Adds multiple chip selects, a runtime clock divider latched per command, and a valid/ready command handshake.
- Adds R1 response and timeout handling, plus optional single-block read with data-token detection.
- Sits between the host command sequencer and SD pins; the read byte stream feeds the block buffer.

Parameters:
- NUM_CS, 2, number of card chip-select lines (>=1); CS_W = max(1, clog2(NUM_CS)) localparam.
- DIV_W, 8, width of the runtime divider value.
- BLK_LEN, 512, data bytes per read block.
- NCR_MAX, 8, max 0xFF bytes polled for the R1 response.
- TOKEN_MAX, 1024, max bytes polled for the start token.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- div_val  in  DIV_W  sclk half-period minus one, in clk cycles.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_init  in  1  request is 80 dummy clocks with all CS high.
- cmd_idx  in  6  command index.
- cmd_arg  in  32  argument.
- cmd_read  in  1  expect a data block after R1.
- cmd_cs  in  CS_W  target card.
- sclk  out  1  SPI clock, idle low (mode 0).
- mosi  out  1  serial out, idle high.
- miso  in  1  serial in.
- cs_n  out  NUM_CS  active-low selects.
- rd_data  out  8  block byte.
- rd_valid  out  1  one-cycle strobe per byte.
- done  out  1  one-cycle completion pulse.
- status  out  2  0 OK, 1 R1 timeout, 2 token timeout, 3 data error token; valid with done.
- r1  out  7  R1 bits [6:0], valid with done.

Behaviour:
- Reset: sclk=0, mosi=1, cs_n all ones, cmd_ready=1, rd_valid=0, done=0, status=0, r1=0, state IDLE.
- Reset mid-transfer aborts immediately. No done is issued.
- Accept on cmd_valid&&cmd_ready. All request fields and div_val are latched at accept; later changes are ignored until the next accept.
- Divider: a counter runs only outside IDLE. sclk toggles every div_val+1 clk cycles, so div_val=0 gives clk/2.
  - rise_tick: miso sampled on the same clk cycle sclk goes high.
  - fall_tick: mosi updated when sclk goes low.
  - First data bit is driven on the accept+1 cycle.
- Byte engine: MSB first, 8 sclk periods per byte. sclk stays low between bytes only while transitioning states; no extra gap cycles.
- States:
  - IDLE.
  - INIT: 10 bytes of 0xFF, cs_n all 1.
  - CMD: 6 bytes, MSB first:
    - {01,idx}
    - arg[31:24] .. arg[7:0]
    - {crc7,1}
  - R1: send 0xFF, poll up to NCR_MAX bytes.
  - TOKEN: send 0xFF, poll up to TOKEN_MAX bytes.
  - DATA: BLK_LEN bytes.
  - CRC16: 2 bytes, discarded.
  - TAIL: one 0xFF byte with CS still low.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - INIT → TAIL (TAIL sent with CS high) → DONE, status 0.
  - In R1, first byte with bit7=0 is latched into r1.
    - If cmd_read=1 and r1==0, go to TOKEN.
    - Otherwise go to TAIL, status 0.
  - NCR_MAX bytes polled with bit7 still 1 → TAIL, status 1, r1=7'h7F.
  - In TOKEN:
    - 0xFE → DATA.
    - 0xFF → keep polling.
    - Any other byte → TAIL, status 3.
    - TOKEN_MAX bytes polled → TAIL, status 2.
- cs_n[cmd_cs] goes low at accept and rises the cycle DONE is entered. Non-selected lines stay high. cmd_cs >= NUM_CS selects no line, but the transfer still runs.
- rd_valid pulses the clk cycle after the 8th rise_tick of each DATA byte. Exactly BLK_LEN pulses per successful read.
- done pulses for one cycle in DONE. cmd_ready returns to 1 on the following cycle.

Optional Feature:
- SD_SPI_CRC7_EN defined: CRC7 (poly x^7+x^3+1) is computed serially over bytes 0-4 of the command.
- SD_SPI_CRC7_EN undefined: the last byte is a constant.
  - 0x95 for idx 0.
  - 0x87 for idx 8.
  - 0x01 otherwise.
- Response handling is identical either way.

Decomposition:
- Package sd_spi_pkg:
  - state enum.
  - status codes: ST_OK, ST_R1_TO, ST_TOK_TO, ST_DATA_ERR.
  - START_TOKEN=8'hFE, FILL=8'hFF.
  - CRC7 constants 0x95 and 0x87.
  - INIT_BYTES=10.
- One sub-module sd_spi_byte: owns the divider, sclk, and the 8-bit shift in/out.
  - Inputs: start, tx byte.
  - Outputs: busy, rx byte, byte_done pulse.
  - The top FSM sequences bytes.

Test Plan:
- Reset with cmd_valid=0 → sclk=0, mosi=1, cs_n=all ones, cmd_ready=1 for 20 cycles.
- cmd_init, div_val=3 → cs_n stays all ones; 88 sclk rising edges (80 INIT + 8 TAIL), each period 8 clk; then one done pulse, status=0.
- CMD0, arg 0, cmd_cs=1, NUM_CS=2:
  - mosi bytes 40 00 00 00 00 95.
  - Card model returns FF FF 01 → r1=7'h01, status=0.
  - Only cs_n[1] goes low.
- CMD17, cmd_read=1, card returns 00, three bytes of FF, FE, 512 bytes i&0xFF, 2 CRC bytes:
  - 512 rd_valid strobes, data 00..FF twice.
  - status=0.
- Card holds miso=1 → after NCR_MAX=8 polled bytes: status=1, r1=7'h7F, no rd_valid.
- Read where the card returns R1 00 then token 0x05 → status=3, zero rd_valid. A second read with the token never sent → status=2 after 1024 polled bytes.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared state encoding, status codes and command constants for the SPI-mode SD master.
package sd_spi_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_CMD,
        S_R1,
        S_TOKEN,
        S_DATA,
        S_CRC16,
        S_TAIL,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_R1_TO    = 2'd1;
    localparam logic [1:0] ST_TOK_TO   = 2'd2;
    localparam logic [1:0] ST_DATA_ERR = 2'd3;

    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] FILL        = 8'hFF;
    localparam logic [7:0] CRC7_CMD0   = 8'h95;
    localparam logic [7:0] CRC7_CMD8   = 8'h87;
    localparam logic [7:0] CRC7_OTHER  = 8'h01;

    localparam int INIT_BYTES = 10;
    localparam int CMD_BYTES  = 6;

    // Bit-serial CRC7 (x^7 + x^3 + 1) over the first five command bytes, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte engine: divider, sclk generation and 8-bit MSB-first shift in/out.
module sd_spi_byte
    import sd_spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       tx,
    input  logic [DIV_W-1:0] div,
    input  logic             miso,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    output logic [7:0]       rx,
    output logic             rx_valid,
    output logic             byte_done
);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       sh_reg;
    logic             sclk_reg;
    logic             mosi_reg;
    logic             busy_reg;
    logic             rxv_reg;
    logic             tick;

    assign tick      = busy_reg && (cnt_reg == div_reg);
    // Asserted on the cycle whose edge ends the byte, so a back-to-back start keeps sclk periodic.
    assign byte_done = tick && sclk_reg && (bit_reg == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= '0;
            cnt_reg  <= '0;
            bit_reg  <= '0;
            sh_reg   <= '0;
            sclk_reg <= 1'b0;
            mosi_reg <= 1'b1;
            busy_reg <= 1'b0;
            rxv_reg  <= 1'b0;
        end else begin
            rxv_reg <= 1'b0;
            if (!busy_reg) begin
                if (start) begin
                    busy_reg <= 1'b1;
                    div_reg  <= div;
                    cnt_reg  <= '0;
                    bit_reg  <= '0;
                    sh_reg   <= tx;
                    mosi_reg <= tx[7];
                end
            end else if (tick) begin
                cnt_reg <= '0;
                if (!sclk_reg) begin
                    sclk_reg <= 1'b1;
                    sh_reg   <= {sh_reg[6:0], miso};
                    rxv_reg  <= (bit_reg == 3'd7);
                end else begin
                    sclk_reg <= 1'b0;
                    if (bit_reg == 3'd7) begin
                        if (start) begin
                            sh_reg   <= tx;
                            mosi_reg <= tx[7];
                            bit_reg  <= '0;
                        end else begin
                            busy_reg <= 1'b0;
                            mosi_reg <= 1'b1;
                        end
                    end else begin
                        bit_reg  <= bit_reg + 3'd1;
                        mosi_reg <= sh_reg[7];
                    end
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy     = busy_reg;
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;
    assign rx       = sh_reg;
    assign rx_valid = rxv_reg;

endmodule

// File: rtl/sd_spi_master.sv
// SPI-mode SD card master: init clocks, command/R1, optional single-block read.
// Define SD_SPI_CRC7_EN to compute the command CRC7 instead of using fixed constants.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int NUM_CS    = 2,
    parameter int DIV_W     = 8,
    parameter int BLK_LEN   = 512,
    parameter int NCR_MAX   = 8,
    parameter int TOKEN_MAX = 1024,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_init,
    input  logic [5:0]        cmd_idx,
    input  logic [31:0]       cmd_arg,
    input  logic              cmd_read,
    input  logic [CS_W-1:0]   cmd_cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic [1:0]        status,
    output logic [6:0]        r1
);

    localparam int CNT_W = $clog2(TOKEN_MAX + BLK_LEN + 16) + 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         status_reg, status_next;
    logic [6:0]         r1_reg, r1_next;
    logic [NUM_CS-1:0]  cs_n_reg, cs_n_next;
    logic               read_reg;
    logic [31:0]        arg_reg;
    logic [7:0]         crc_reg;
    logic [7:0]         crc_byte;
    logic [7:0]         cmd_byte;
    logic [NUM_CS-1:0]  sel_dec;
    logic               accept;
    logic               byte_start;
    logic [7:0]         byte_tx;
    logic               byte_busy;
    logic [7:0]         byte_rx;
    logic               byte_rxv;
    logic               byte_done;

    // Out-of-range selects decode to no line at all.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_sel
        assign sel_dec[gi] = (cmd_cs == CS_W'(gi));
    end

`ifdef SD_SPI_CRC7_EN
    assign crc_byte = {crc7({2'b01, cmd_idx, cmd_arg}), 1'b1};
`else
    always_comb begin
        case (cmd_idx)
            6'd0:    crc_byte = CRC7_CMD0;
            6'd8:    crc_byte = CRC7_CMD8;
            default: crc_byte = CRC7_OTHER;
        endcase
    end
`endif

    always_comb begin
        case (cnt_reg[2:0])
            3'd1:    cmd_byte = arg_reg[31:24];
            3'd2:    cmd_byte = arg_reg[23:16];
            3'd3:    cmd_byte = arg_reg[15:8];
            3'd4:    cmd_byte = arg_reg[7:0];
            default: cmd_byte = crc_reg;
        endcase
    end

    assign cmd_ready = (state_reg == S_IDLE) && !byte_busy;
    assign accept    = cmd_valid && cmd_ready;

    // cnt_reg holds the number of bytes already started in the current state.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        status_next = status_reg;
        r1_next     = r1_reg;
        cs_n_next   = cs_n_reg;
        byte_start  = 1'b0;
        byte_tx     = FILL;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    byte_start  = 1'b1;
                    cnt_next    = CNT_W'(1);
                    status_next = ST_OK;
                    r1_next     = '0;
                    if (cmd_init) begin
                        state_next = S_INIT;
                    end else begin
                        state_next = S_CMD;
                        byte_tx    = {2'b01, cmd_idx};
                        cs_n_next  = ~sel_dec;
                    end
                end
            end
            S_INIT: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (cnt_reg == CNT_W'(INIT_BYTES)) state_next = S_TAIL;
                    else cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (cnt_reg == CNT_W'(CMD_BYTES)) begin
                        state_next = S_R1;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        byte_tx  = cmd_byte;
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (!byte_rx[7]) begin
                        r1_next = byte_rx[6:0];
                        if (read_reg && (byte_rx[6:0] == 7'd0)) begin
                            state_next = S_TOKEN;
                            cnt_next   = CNT_W'(1);
                        end else begin
                            state_next = S_TAIL;
                        end
                    end else if (cnt_reg == CNT_W'(NCR_MAX)) begin
                        state_next  = S_TAIL;
                        status_next = ST_R1_TO;
                        r1_next     = 7'h7F;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (byte_rx == START_TOKEN) begin
                        state_next = S_DATA;
                        cnt_next   = CNT_W'(1);
                    end else if (byte_rx != FILL) begin
                        state_next  = S_TAIL;
                        status_next = ST_DATA_ERR;
                    end else if (cnt_reg == CNT_W'(TOKEN_MAX)) begin
                        state_next  = S_TAIL;
                        status_next = ST_TOK_TO;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (cnt_reg == CNT_W'(BLK_LEN)) begin
                        state_next = S_CRC16;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_CRC16: begin
                if (byte_done) begin
                    byte_start = 1'b1;
                    if (cnt_reg == CNT_W'(2)) state_next = S_TAIL;
                    else cnt_next = cnt_reg + 1'b1;
                end
            end
            S_TAIL: begin
                if (byte_done) begin
                    state_next = S_DONE;
                    cs_n_next  = '1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            status_reg <= ST_OK;
            r1_reg     <= '0;
            cs_n_reg   <= '1;
            read_reg   <= 1'b0;
            arg_reg    <= '0;
            crc_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            status_reg <= status_next;
            r1_reg     <= r1_next;
            cs_n_reg   <= cs_n_next;
            if (accept) begin
                read_reg <= cmd_read;
                arg_reg  <= cmd_arg;
                crc_reg  <= crc_byte;
            end
        end
    end

    sd_spi_byte #(
        .DIV_W (DIV_W)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .start     (byte_start),
        .tx        (byte_tx),
        .div       (div_val),
        .miso      (miso),
        .busy      (byte_busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .rx        (byte_rx),
        .rx_valid  (byte_rxv),
        .byte_done (byte_done)
    );

    assign cs_n     = cs_n_reg;
    assign rd_data  = byte_rx;
    assign rd_valid = byte_rxv && (state_reg == S_DATA);
    assign done     = (state_reg == S_DONE);
    assign status   = status_reg;
    assign r1       = r1_reg;

endmodule
